// File: rtl/aes_core_if.sv
// Block-level signal bundle for the iterative AES-128 core.
// The master side drives the start/data inputs, the slave side returns results.
interface aes_core_if;
    logic         iStart;
    logic [127:0] iPlaintext;
    logic [127:0] iKey;
    logic [127:0] oCiphertext;
    logic         oDone;

    modport master (
        output iStart, iPlaintext, iKey,
        input  oCiphertext, oDone
    );

    modport slave (
        input  iStart, iPlaintext, iKey,
        output oCiphertext, oDone
    );
endinterface

// File: rtl/aes_core.sv
// Iterative AES-128 encryption core: one round per clock.
// The key schedule is expanded on the fly from the registered round key.
module aes_core (
    input  logic       iClk,
    input  logic       iRst,
    aes_core_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;
    logic [127:0] next_key;
    logic [127:0] round_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k,
                                            input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, t, w4, w5, w6, w7;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w4 = w0 ^ t ^ {rc, 24'h0};
        w5 = w4 ^ w1;
        w6 = w5 ^ w2;
        w7 = w6 ^ w3;
        return {w4, w5, w6, w7};
    endfunction

    // Round datapath: next round key and the round result.
    always_comb begin
        logic [127:0] ss;
        logic [127:0] mc;
        next_key = expand(rkey_q, rcon(round_q));
        ss = sub_shift(state_q);
        mc = {mix_col(ss[127:96]), mix_col(ss[95:64]),
              mix_col(ss[63:32]), mix_col(ss[31:0])};
        round_out = ((round_q == 4'd10) ? ss : mc) ^ next_key;
    end

    // Control: load on start in IDLE, run ten rounds, publish the result.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (bus.iStart) begin
                    state_d = bus.iPlaintext ^ bus.iKey;
                    rkey_d  = bus.iKey;
                    round_d = 4'd1;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                state_d = round_out;
                rkey_d  = next_key;
                if (round_q == 4'd10) begin
                    ct_d    = round_out;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= '0;
            rkey_q  <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    assign bus.oCiphertext = ct_q;
    assign bus.oDone       = done_q;
endmodule

// File: tb/tb_aes_core.sv
// Self-checking bench for aes_core: known vectors, random blocks,
// busy-time input changes, mid-run reset and back-to-back operation.
module tb_aes_core;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [7:0] sbt [256];

    aes_core_if bus ();

    aes_core dut (
        .iClk (clk),
        .iRst (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                     ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] pt,
                                             input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   w [4];
        logic [7:0]   rc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            w[0] = sbt[k[13]] ^ rc;
            w[1] = sbt[k[14]];
            w[2] = sbt[k[15]];
            w[3] = sbt[k[12]];
            for (int j = 0; j < 4; j++) k[j] = k[j] ^ w[j];
            for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) s[i] = sbt[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // One-cycle start pulse; returns at the falling edge after the start edge.
    task automatic start_op(input logic [127:0] pt, input logic [127:0] key);
        @(negedge clk);
        bus.iPlaintext = pt;
        bus.iKey       = key;
        bus.iStart     = 1'b1;
        @(negedge clk);
        bus.iStart     = 1'b0;
    endtask

    // Cycles until oDone is seen (bounded); lat = -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.oDone === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.iStart     = 1'b0;
        bus.iPlaintext = '0;
        bus.iKey       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.oCiphertext !== 128'h0) begin
            failures++;
            $display("FAIL reset_ct got=%h exp=%h", bus.oCiphertext, 128'h0);
        end
        checks++;
        if (bus.oDone !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", bus.oDone);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [127:0] pts [3];
        logic [127:0] keys [3];
        logic [127:0] cts [3];
        int lat;
        pts  = '{C1_PT, B_PT, 128'h0};
        keys = '{C1_KEY, B_KEY, 128'h0};
        cts  = '{C1_CT, B_CT, Z_CT};
        for (int v = 0; v < 3; v++) begin
            start_op(pts[v], keys[v]);
            wait_done(lat);
            checks++;
            if (lat !== 10) begin
                failures++;
                $display("FAIL vec%0d_latency got=%0d exp=10", v, lat);
            end
            checks++;
            if (bus.oCiphertext !== cts[v]) begin
                failures++;
                $display("FAIL vec%0d_ct got=%h exp=%h", v, bus.oCiphertext, cts[v]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, key, exp;
        int lat;
        for (int v = 0; v < 6; v++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            exp = ref_aes(pt, key);
            start_op(pt, key);
            wait_done(lat);
            checks++;
            if (lat !== 10 || bus.oCiphertext !== exp) begin
                failures++;
                $display("FAIL rand%0d lat=%0d got=%h exp=%h", v, lat, bus.oCiphertext, exp);
            end
        end
    endtask

    task automatic test_busy();
        logic [127:0] pt, key, exp;
        int pulses, at;
        pt     = {$urandom, $urandom, $urandom, $urandom};
        key    = {$urandom, $urandom, $urandom, $urandom};
        exp    = ref_aes(pt, key);
        pulses = 0;
        at     = -1;
        start_op(pt, key);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (bus.oDone === 1'b1) begin
                pulses++;
                at = n;
            end
            if (n >= 3 && n <= 8) begin
                bus.iStart     = 1'b1;
                bus.iPlaintext = {$urandom, $urandom, $urandom, $urandom};
                bus.iKey       = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                bus.iStart = 1'b0;
            end
        end
        checks++;
        if (pulses !== 1 || at !== 10) begin
            failures++;
            $display("FAIL busy_done pulses=%0d at=%0d exp pulses=1 at=10", pulses, at);
        end
        checks++;
        if (bus.oCiphertext !== exp) begin
            failures++;
            $display("FAIL busy_ct_held got=%h exp=%h", bus.oCiphertext, exp);
        end
    endtask

    task automatic test_reset_mid();
        int pulses, lat;
        pulses = 0;
        start_op(B_PT, B_KEY);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.oCiphertext !== 128'h0 || bus.oDone !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs ct=%h done=%b exp ct=0 done=0",
                     bus.oCiphertext, bus.oDone);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (bus.oDone === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL midreset_no_done got=%0d exp=0", pulses);
        end
        start_op(C1_PT, C1_KEY);
        wait_done(lat);
        checks++;
        if (lat !== 10 || bus.oCiphertext !== C1_CT) begin
            failures++;
            $display("FAIL midreset_rerun lat=%0d got=%h exp=%h", lat, bus.oCiphertext, C1_CT);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        start_op(C1_PT, C1_KEY);
        wait_done(lat1);
        checks++;
        if (lat1 !== 10 || bus.oCiphertext !== C1_CT) begin
            failures++;
            $display("FAIL b2b_first lat=%0d got=%h exp=%h", lat1, bus.oCiphertext, C1_CT);
        end
        bus.iPlaintext = B_PT;
        bus.iKey       = B_KEY;
        bus.iStart     = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        checks++;
        if (bus.oDone !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pulse_width got=%b exp=0", bus.oDone);
        end
        wait_done(lat2);
        checks++;
        if (lat2 !== 10 || bus.oCiphertext !== B_CT) begin
            failures++;
            $display("FAIL b2b_second lat=%0d got=%h exp=%h", lat2, bus.oCiphertext, B_CT);
        end
        @(negedge clk);
        checks++;
        if (bus.oDone !== 1'b0 || bus.oCiphertext !== B_CT) begin
            failures++;
            $display("FAIL b2b_after done=%b ct=%h exp done=0 ct=%h",
                     bus.oDone, bus.oCiphertext, B_CT);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        build_sbox();
        test_reset();
        test_vectors();
        test_random();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
